// File: rtl/rcu_pkg.sv
// Shared types for the end-of-program register-file checker.
package rcu_pkg;

    // Upper bounds for the packed table-entry view. Narrower instances zero-extend into it.
    localparam int unsigned RCU_AW_MAX = 16;
    localparam int unsigned RCU_DW_MAX = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ADDR,
        ST_DATA,
        ST_DONE
    } rcu_state_e;

    typedef struct packed {
        logic                  valid;
        logic [RCU_AW_MAX-1:0] addr;
        logic [RCU_DW_MAX-1:0] val;
    } rcu_entry_t;

    // Saturating add used for the mismatch counter.
    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned lim);
        return ((a + b) > lim) ? lim : (a + b);
    endfunction

endpackage

// File: rtl/rcu_exp_table.sv
// Expected-value table: one write port and a parallel compare of every entry
// against the register currently being scanned.
module rcu_exp_table
    import rcu_pkg::*;
#(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned NCHECK = 4,
    parameter int unsigned AW     = 5,
    parameter int unsigned IW     = 2
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic              clr_i,
    input  logic [IW-1:0]     idx_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [XLEN-1:0]   val_i,
    input  logic [AW-1:0]     cmp_addr_i,
    input  logic [XLEN-1:0]   cmp_data_i,
    output logic [NCHECK-1:0] mismatch_o
);

    logic [NCHECK-1:0] valid_q, valid_d;
    logic [AW-1:0]     addr_q [NCHECK];
    logic [XLEN-1:0]   val_q  [NCHECK];
    rcu_entry_t        entry  [NCHECK];

    // Next valid bits: a clear wipes the table, then a same-cycle write re-validates its entry.
    // NOTE: combinational logic uses blocking '=' so later statements see earlier results.
    always_comb begin
        valid_d = clr_i ? '0 : valid_q;
        for (int i = 0; i < NCHECK; i++) begin
            if (we_i && (idx_i == IW'(i))) begin
                valid_d[i] = 1'b1;
            end
        end
    end

    // Valid bits register.
    // NOTE: only the valid bits are reset; payload is ignored while invalid, so it needs no reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Payload storage for the addressed entry.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < NCHECK; i++) begin
            if (we_i && (idx_i == IW'(i))) begin
                addr_q[i] <= addr_i;
                val_q[i]  <= val_i;
            end
        end
    end

    // Parallel compare: flag each valid entry that targets this register but disagrees.
    always_comb begin
        entry      = '{default: '0};
        mismatch_o = '0;
        for (int i = 0; i < NCHECK; i++) begin
            entry[i] = '{valid: valid_q[i],
                         addr:  RCU_AW_MAX'(addr_q[i]),
                         val:   RCU_DW_MAX'(val_q[i])};
            mismatch_o[i] = entry[i].valid
                         && (entry[i].addr == RCU_AW_MAX'(cmp_addr_i))
                         && (entry[i].val  != RCU_DW_MAX'(cmp_data_i));
        end
    end

endmodule

// File: rtl/reg_check_unit.sv
// End-of-program register-file checker: waits for halt (or times out), scans
// every register through a read port, streams each value out and compares it
// against the expected-value table.
module reg_check_unit
    import rcu_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NREGS   = 32,
    parameter int unsigned NCHECK  = 4,
    parameter int unsigned TIMEOUT = 1000,
    parameter bit          DUMP_EN = 1'b1,
    localparam int unsigned AW = (NREGS > 1) ? $clog2(NREGS) : 1,
    localparam int unsigned IW = (NCHECK > 1) ? $clog2(NCHECK) : 1,
    localparam int unsigned CW = $clog2(NCHECK + 1)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            start_i,
    input  logic            halt_i,
    input  logic            exp_we_i,
    input  logic [IW-1:0]   exp_idx_i,
    input  logic [AW-1:0]   exp_addr_i,
    input  logic [XLEN-1:0] exp_val_i,
    input  logic            exp_clr_i,
    output logic [AW-1:0]   rf_raddr_o,
    input  logic [XLEN-1:0] rf_rdata_i,
    output logic            dump_valid_o,
    input  logic            dump_ready_i,
    output logic [AW-1:0]   dump_addr_o,
    output logic [XLEN-1:0] dump_data_o,
    output logic            busy_o,
    output logic            done_o,
    output logic            pass_o,
    output logic            timeout_o,
    output logic [CW-1:0]   fail_count_o,
    output logic [AW-1:0]   first_fail_o
);

    localparam int unsigned    TW       = $clog2(TIMEOUT + 2);
    localparam logic [TW-1:0]  TO_LAST  = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [AW-1:0]  IDX_LAST = AW'(NREGS - 1);

    rcu_state_e        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [TW-1:0]     cnt_q, cnt_d;
    logic              cap_q, cap_d;
    logic [XLEN-1:0]   dump_data_q, dump_data_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic [CW-1:0]     fail_count_q, fail_count_d;
    logic [AW-1:0]     first_fail_q, first_fail_d;
    logic [NCHECK-1:0] mismatch;
    logic [CW-1:0]     mis_cnt;
    logic              idle;
    logic              beat_go;

    assign idle    = (state_q == ST_IDLE);
    assign beat_go = !DUMP_EN || dump_ready_i;

    rcu_exp_table #(
        .XLEN   (XLEN),
        .NCHECK (NCHECK),
        .AW     (AW),
        .IW     (IW)
    ) u_table (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .we_i       (exp_we_i && idle),
        .clr_i      (exp_clr_i && idle),
        .idx_i      (exp_idx_i),
        .addr_i     (exp_addr_i),
        .val_i      (exp_val_i),
        .cmp_addr_i (idx_q),
        .cmp_data_i (rf_rdata_i),
        .mismatch_o (mismatch)
    );

    // Count how many table entries disagree with the register on the read port.
    always_comb begin
        mis_cnt = '0;
        for (int i = 0; i < NCHECK; i++) begin
            mis_cnt = mis_cnt + CW'(mismatch[i]);
        end
    end

    // Next-state and datapath update for the arm/wait/scan/report sequence.
    // NOTE: every variable gets its hold value first, so no path infers a latch.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cnt_d        = cnt_q;
        cap_d        = cap_q;
        dump_data_d  = dump_data_q;
        done_d       = done_q;
        pass_d       = pass_q;
        timeout_d    = timeout_q;
        fail_count_d = fail_count_q;
        first_fail_d = first_fail_q;

        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_i) begin
                    state_d      = ST_WAIT;
                    cnt_d        = '0;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    timeout_d    = 1'b0;
                    fail_count_d = '0;
                    first_fail_d = '0;
                end
            end
            ST_WAIT: begin
                if (halt_i) begin
                    state_d = ST_ADDR;
                    idx_d   = '0;
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    timeout_d = 1'b1;
                    pass_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ADDR: begin
                state_d = ST_DATA;
                cap_d   = 1'b0;
            end
            ST_DATA: begin
                // Compare exactly once per register, on the first DATA cycle.
                if (!cap_q) begin
                    cap_d        = 1'b1;
                    dump_data_d  = rf_rdata_i;
                    fail_count_d = CW'(sat_add(32'(fail_count_q), 32'(mis_cnt), NCHECK));
                    if ((fail_count_q == '0) && (mis_cnt != '0)) begin
                        first_fail_d = idx_q;
                    end
                end
                if (beat_go) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = (fail_count_d == '0);
                    end else begin
                        state_d = ST_ADDR;
                        idx_d   = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            cnt_q        <= '0;
            cap_q        <= 1'b0;
            dump_data_q  <= '0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            timeout_q    <= 1'b0;
            fail_count_q <= '0;
            first_fail_q <= '0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            dump_data_q  <= dump_data_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            timeout_q    <= timeout_d;
            fail_count_q <= fail_count_d;
            first_fail_q <= first_fail_d;
        end
    end

    // The first DATA cycle forwards the read data directly; afterwards the
    // captured copy keeps the beat stable while the sink stalls.
    assign dump_data_o  = ((state_q == ST_DATA) && !cap_q) ? rf_rdata_i : dump_data_q;
    assign dump_valid_o = DUMP_EN && (state_q == ST_DATA);
    assign dump_addr_o  = idx_q;
    assign rf_raddr_o   = idx_q;
    assign busy_o       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign done_o       = done_q;
    assign pass_o       = pass_q;
    assign timeout_o    = timeout_q;
    assign fail_count_o = fail_count_q;
    assign first_fail_o = first_fail_q;

endmodule
